// File: rtl/sigma_np_if.sv
// Sample-side bus of the N-point summer: sample strobe, controls and result.
interface sigma_np_if #(
  parameter int DW = 8,
  parameter int OW = 12
);
  logic [DW-1:0] data_in;
  logic          syn_in;
  logic          mode;
  logic          avg;
  logic          clr;
  logic [OW-1:0] data_out;
  logic          syn_out;

  modport master (
    output data_in, syn_in, mode, avg, clr,
    input  data_out, syn_out
  );

  modport slave (
    input  data_in, syn_in, mode, avg, clr,
    output data_out, syn_out
  );
endinterface

// File: rtl/sigma_np.sv
// N-point summer (N = 2^LOG2N). Block mode emits one sum per N samples;
// sliding mode emits a moving N-point sum per sample once the window is full.
// The result is optionally divided by N (arithmetic shift) to give the mean.
module sigma_np #(
  parameter int DW       = 8,
  parameter int LOG2N    = 4,
  parameter bit SIGN_MAG = 1'b1
) (
  input  logic     clk,
  input  logic     res,
  sigma_np_if.slave bus
);
  localparam int OW = DW + LOG2N;
  localparam int N  = 1 << LOG2N;
  localparam logic [LOG2N:0]   FULL = (LOG2N + 1)'(N);
  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  logic                 syn_d;
  logic                 mode_q;
  logic                 strb;
  logic                 resync;
  logic signed [OW-1:0] sum;
  logic [LOG2N-1:0]     cnt;
  logic [LOG2N-1:0]     wp;
  logic [LOG2N:0]       fill;
  logic [LOG2N:0]       fill_nx;
  logic signed [OW-1:0] hist [N];
  logic signed [OW-1:0] mag;
  logic signed [OW-1:0] d;
  logic signed [OW-1:0] old;
  logic signed [OW-1:0] blk_sum;
  logic signed [OW-1:0] sld_sum;
  logic [OW-1:0]        data_out_q;
  logic                 syn_out_q;

  assign bus.data_out = data_out_q;
  assign bus.syn_out  = syn_out_q;

  // Mean is the sum divided by N, rounding toward minus infinity.
  function automatic logic signed [OW-1:0] scale(input logic signed [OW-1:0] s,
                                                 input logic a);
    return a ? (s >>> LOG2N) : s;
  endfunction

  // Convert the incoming sample to a sign-extended two's-complement word.
  always_comb begin
    mag = '0;
    d   = '0;
    if (SIGN_MAG) begin
      mag = {{(OW - DW + 1){1'b0}}, bus.data_in[DW-2:0]};
      d   = bus.data_in[DW-1] ? -mag : mag;
    end else begin
      d = {{(OW - DW){bus.data_in[DW-1]}}, bus.data_in};
    end
  end

  // Edge detect on the sample clock, resync request and candidate sums for both modes.
  always_comb begin
    strb    = bus.syn_in & ~syn_d;
    resync  = bus.clr | (bus.mode != mode_q);
    blk_sum = sum + d;
    old     = (fill == FULL) ? hist[wp] : '0;
    sld_sum = sum + d - old;
    fill_nx = (fill == FULL) ? fill : fill + 1'b1;
  end

  // Accumulation state and result register; resync wins over a coincident strobe.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      syn_d      <= 1'b0;
      mode_q     <= bus.mode;
      sum        <= '0;
      cnt        <= '0;
      wp         <= '0;
      fill       <= '0;
      data_out_q <= '0;
      syn_out_q  <= 1'b0;
    end else begin
      syn_d     <= bus.syn_in;
      syn_out_q <= 1'b0;
      if (resync) begin
        sum    <= '0;
        cnt    <= '0;
        wp     <= '0;
        fill   <= '0;
        mode_q <= bus.mode;
      end else if (strb) begin
        if (!mode_q) begin
          if (cnt == LAST) begin
            data_out_q <= scale(blk_sum, bus.avg);
            syn_out_q  <= 1'b1;
            sum        <= '0;
            cnt        <= '0;
          end else begin
            sum <= blk_sum;
            cnt <= cnt + 1'b1;
          end
        end else begin
          sum  <= sld_sum;
          wp   <= wp + 1'b1;
          fill <= fill_nx;
          if (fill_nx == FULL) begin
            data_out_q <= scale(sld_sum, bus.avg);
            syn_out_q  <= 1'b1;
          end
        end
      end
    end
  end

  // Sliding-window history; contents are only read once the window is full, so no reset.
  always_ff @(posedge clk) begin
    if (strb && !resync && mode_q) begin
      hist[wp] <= d;
    end
  end
endmodule

// File: tb/tb_sigma_np.sv
// Bench for sigma_np: a sign-magnitude and a two's-complement instance share
// one stimulus stream; expected results come from a window-level model.
module tb_sigma_np;
  localparam int DW    = 8;
  localparam int LOG2N = 4;
  localparam int N     = 1 << LOG2N;
  localparam int OW    = DW + LOG2N;

  logic clk;
  logic res;
  int   total;
  int   bad;

  sigma_np_if #(.DW(DW), .OW(OW)) bus0 ();
  sigma_np_if #(.DW(DW), .OW(OW)) bus1 ();

  assign bus1.data_in = bus0.data_in;
  assign bus1.syn_in  = bus0.syn_in;
  assign bus1.mode    = bus0.mode;
  assign bus1.avg     = bus0.avg;
  assign bus1.clr     = bus0.clr;

  sigma_np #(.DW(DW), .LOG2N(LOG2N), .SIGN_MAG(1'b1)) dut_sm (
    .clk (clk),
    .res (res),
    .bus (bus0)
  );

  sigma_np #(.DW(DW), .LOG2N(LOG2N), .SIGN_MAG(1'b0)) dut_tc (
    .clk (clk),
    .res (res),
    .bus (bus1)
  );

  // Free-running system clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [OW-1:0] q0 [$];
  logic [OW-1:0] q1 [$];
  logic [OW-1:0] last0;
  logic [OW-1:0] last1;
  logic          mode_m;
  int            blk0 [$];
  int            blk1 [$];
  int            win0 [$];
  int            win1 [$];

  function automatic int smConv(input logic [7:0] v);
    int m;
    m = int'(v[6:0]);
    return v[7] ? -m : m;
  endfunction

  function automatic int tcConv(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  function automatic int qSum(input int q [$]);
    int s;
    s = 0;
    foreach (q[k]) s += q[k];
    return s;
  endfunction

  function automatic logic [OW-1:0] calc(input int s, input logic a);
    int r;
    r = a ? (s >>> LOG2N) : s;
    return r[OW-1:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic modelClear();
    blk0.delete();
    blk1.delete();
    win0.delete();
    win1.delete();
  endtask

  // One accepted sample: block windows close every N samples, sliding window emits once full.
  task automatic modelSample(input logic [7:0] v);
    if (!mode_m) begin
      blk0.push_back(smConv(v));
      blk1.push_back(tcConv(v));
      if (blk0.size() == N) begin
        last0 = calc(qSum(blk0), bus0.avg);
        last1 = calc(qSum(blk1), bus0.avg);
        q0.push_back(last0);
        q1.push_back(last1);
        blk0.delete();
        blk1.delete();
      end
    end else begin
      win0.push_back(smConv(v));
      win1.push_back(tcConv(v));
      if (win0.size() > N) begin
        void'(win0.pop_front());
        void'(win1.pop_front());
      end
      if (win0.size() == N) begin
        last0 = calc(qSum(win0), bus0.avg);
        last1 = calc(qSum(win1), bus0.avg);
        q0.push_back(last0);
        q1.push_back(last1);
      end
    end
  endtask

  task automatic applyStimulus(input logic [7:0] v, input int hi, input int lo);
    @(posedge clk);
    #1;
    bus0.data_in = v;
    bus0.syn_in  = 1'b1;
    modelSample(v);
    repeat (hi) @(posedge clk);
    #1;
    bus0.syn_in = 1'b0;
    repeat (lo) @(posedge clk);
  endtask

  task automatic applyResync(input bit use_clr);
    @(posedge clk);
    #1;
    if (use_clr) bus0.clr = 1'b1;
    else         bus0.mode = ~bus0.mode;
    modelClear();
    mode_m = bus0.mode;
    @(posedge clk);
    #1;
    bus0.clr = 1'b0;
    checkOutput("hold_sm", 32'(bus0.data_out), 32'(last0));
    checkOutput("hold_tc", 32'(bus1.data_out), 32'(last1));
  endtask

  task automatic applyClrStrobe(input logic [7:0] v);
    @(posedge clk);
    #1;
    bus0.clr     = 1'b1;
    bus0.syn_in  = 1'b1;
    bus0.data_in = v;
    modelClear();
    @(posedge clk);
    #1;
    bus0.clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus0.syn_in = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic applyReset();
    @(posedge clk);
    #3;
    res = 1'b0;
    modelClear();
    mode_m = bus0.mode;
    last0  = '0;
    last1  = '0;
    #1;
    checkOutput("rst_data_sm", 32'(bus0.data_out), 32'h0);
    checkOutput("rst_syn_sm", 32'(bus0.syn_out), 32'h0);
    checkOutput("rst_data_tc", 32'(bus1.data_out), 32'h0);
    checkOutput("rst_syn_tc", 32'(bus1.syn_out), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    res = 1'b1;
  endtask

  // Pop and compare whenever the sign-magnitude instance presents a result.
  always @(negedge clk) begin
    if (bus0.syn_out) begin
      total++;
      if (q0.size() == 0) begin
        bad++;
        $display("[TB] FAIL sm_unexpected: got %0h expected no result", bus0.data_out);
      end else begin
        logic [OW-1:0] e;
        e = q0.pop_front();
        if (bus0.data_out !== e) begin
          bad++;
          $display("[TB] FAIL sm_result: got %0h expected %0h", bus0.data_out, e);
        end
      end
    end
  end

  // Pop and compare whenever the two's-complement instance presents a result.
  always @(negedge clk) begin
    if (bus1.syn_out) begin
      total++;
      if (q1.size() == 0) begin
        bad++;
        $display("[TB] FAIL tc_unexpected: got %0h expected no result", bus1.data_out);
      end else begin
        logic [OW-1:0] e;
        e = q1.pop_front();
        if (bus1.data_out !== e) begin
          bad++;
          $display("[TB] FAIL tc_result: got %0h expected %0h", bus1.data_out, e);
        end
      end
    end
  end

  initial begin
    total        = 0;
    bad          = 0;
    res          = 1'b0;
    bus0.data_in = '0;
    bus0.syn_in  = 1'b0;
    bus0.mode    = 1'b0;
    bus0.avg     = 1'b0;
    bus0.clr     = 1'b0;
    mode_m       = 1'b0;
    last0        = '0;
    last1        = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("init_data_sm", 32'(bus0.data_out), 32'h0);
    checkOutput("init_syn_sm", 32'(bus0.syn_out), 32'h0);
    checkOutput("init_data_tc", 32'(bus1.data_out), 32'h0);
    @(negedge clk);
    res = 1'b1;

    $display("[TB] block sums, period 20");
    repeat (32) applyStimulus(8'h01, 10, 9);
    checkOutput("blk_ones", 32'(bus0.data_out), 32'h010);

    $display("[TB] negative, mean and minus zero");
    repeat (16) applyStimulus(8'h81, 1, 1);
    bus0.avg = 1'b1;
    repeat (16) applyStimulus(8'h81, 1, 1);
    checkOutput("blk_mean_m1", 32'(bus0.data_out), 32'hFFF);
    bus0.avg = 1'b0;
    repeat (16) applyStimulus(8'h80, 1, 1);

    $display("[TB] extremes");
    repeat (16) applyStimulus(8'hFF, 1, 1);
    checkOutput("blk_min_sm", 32'(bus0.data_out), 32'h810);
    repeat (16) applyStimulus(8'h7F, 2, 1);
    repeat (16) applyStimulus(8'h80, 1, 2);
    checkOutput("blk_min_tc", 32'(bus1.data_out), 32'h800);

    $display("[TB] sliding ramp");
    applyResync(1'b0);
    for (int i = 1; i <= 20; i++) applyStimulus(8'(i), 1, 1);
    checkOutput("sld_ramp", 32'(bus0.data_out), 32'd200);

    $display("[TB] resync by mode change and by clear");
    applyResync(1'b0);
    repeat (7) applyStimulus(8'h05, 1, 1);
    applyResync(1'b0);
    for (int i = 0; i < 16; i++) applyStimulus(8'(i + 3), 1, 1);
    applyResync(1'b0);
    repeat (7) applyStimulus(8'h05, 1, 1);
    applyResync(1'b1);
    for (int i = 0; i < 15; i++) applyStimulus(8'(i + 3), 1, 1);
    applyStimulus(8'd18, 50, 2);
    applyClrStrobe(8'h33);
    repeat (16) applyStimulus(8'h02, 1, 1);

    $display("[TB] reset mid-window");
    repeat (9) applyStimulus(8'h11, 1, 1);
    applyReset();
    repeat (16) applyStimulus(8'h03, 1, 1);

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(99, 0));
      if (r < 3)      applyResync(1'b1);
      else if (r < 6) applyResync(1'b0);
      else if (r < 8) applyClrStrobe(8'($urandom));
      else if (r < 9) applyReset();
      if ($urandom_range(9, 0) == 0) bus0.avg = ~bus0.avg;
      applyStimulus(8'($urandom), int'($urandom_range(3, 1)), int'($urandom_range(2, 1)));
    end

    repeat (4) @(posedge clk);
    #1;
    checkOutput("sb_sm_empty", 32'(q0.size()), 32'd0);
    checkOutput("sb_tc_empty", 32'(q1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
